// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory / write-back stage.
//   - funct3 encodings for loads and stores
//   - mem_wb_stage FSM state type
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } mem_wb_state_t;

endpackage

// File: rtl/load_aligner.sv
// Load data extraction: selects the byte / halfword lane addressed by the
// low address bits and sign- or zero-extends it according to funct3.
//   rdata    : raw 32-bit word returned by data memory
//   addr     : byte offset within the word (effective address [1:0])
//   funct3   : load size / signedness
//   data_out : value to be written to the register file
module load_aligner
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[8*addr +: 8];
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data_out = rdata;
        case (funct3)
            F3_LB:   data_out = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  data_out = {24'h0, w_byte};
            F3_LH:   data_out = {{16{w_half[15]}}, w_half};
            F3_LHU:  data_out = {16'h0, w_half};
            default: data_out = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Combined MEM / WB stage of the RV32I pipeline.
// ALU results retire one per cycle; loads and stores go through a
// req/ack data-memory handshake with a bounded wait.
//   clk, rst                : clock, synchronous active-high reset
//   ex_*                    : instruction from EX (valid/ready handshake)
//   dmem_req/we/addr/wdata/be, dmem_ack/rdata : data-memory port
//   wr_n, wr_addr, data_in  : register-file write port (wr_n active low)
//   err                     : one-cycle pulse on misaligned/illegal access or timeout
module mem_wb_stage
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wr_n,
    output logic [4:0]  wr_addr,
    output logic [31:0] data_in,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_wb_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_rd;
    logic [2:0]    r_f3;
    logic [1:0]    r_lane;
    logic          r_is_load;
    logic          r_wr_en;

    logic          w_accept;
    logic          w_is_mem;
    logic          w_bad;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load_data;

    assign ex_ready = (r_state == IDLE) && !rst;
    assign w_accept = ex_valid && ex_ready;
    assign w_is_mem = ex_is_load || ex_is_store;

    // Misalignment and unused funct3 encodings both abort the access.
    // A op flagged as both load and store is treated as a load.
    always_comb begin
        w_bad = 1'b0;
        if (ex_is_load) begin
            case (ex_funct3)
                F3_LB, F3_LBU: w_bad = 1'b0;
                F3_LH, F3_LHU: w_bad = ex_result[0];
                F3_LW:         w_bad = |ex_result[1:0];
                default:       w_bad = 1'b1;
            endcase
        end else begin
            case (ex_funct3)
                F3_SB:   w_bad = 1'b0;
                F3_SH:   w_bad = ex_result[0];
                F3_SW:   w_bad = |ex_result[1:0];
                default: w_bad = 1'b1;
            endcase
        end
    end

    // Store formatting: data replicated across lanes so memory only needs be.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ex_result[1:0];
                w_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {ex_result[1], 1'b0};
                w_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex_store_data;
            end
        endcase
    end

    load_aligner u_load_aligner (
        .rdata    (dmem_rdata),
        .addr     (r_lane),
        .funct3   (r_f3),
        .data_out (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_f3       <= '0;
            r_lane     <= '0;
            r_is_load  <= 1'b0;
            r_wr_en    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            wr_n       <= 1'b1;
            wr_addr    <= '0;
            data_in    <= '0;
            err        <= 1'b0;
        end else begin
            err  <= 1'b0;
            wr_n <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem) begin
                            if (w_bad) begin
                                err <= 1'b1;
                            end else begin
                                r_state    <= MEM;
                                r_cnt      <= '0;
                                dmem_req   <= 1'b1;
                                dmem_we    <= ex_is_store && !ex_is_load;
                                dmem_addr  <= {ex_result[31:2], 2'b00};
                                dmem_be    <= w_be;
                                dmem_wdata <= w_wdata;
                                r_rd       <= ex_rd;
                                r_f3       <= ex_funct3;
                                r_lane     <= ex_result[1:0];
                                r_is_load  <= ex_is_load;
                                r_wr_en    <= ex_is_load && ex_reg_write && (ex_rd != 5'd0);
                            end
                        end else if (ex_reg_write && (ex_rd != 5'd0)) begin
                            wr_n    <= 1'b0;
                            wr_addr <= ex_rd;
                            data_in <= ex_result;
                        end
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (r_is_load) begin
                            // Write is presented during WB; WB then returns to IDLE.
                            r_state <= WB;
                            if (r_wr_en) begin
                                wr_n    <= 1'b0;
                                wr_addr <= r_rd;
                                data_in <= w_load_data;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        err      <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_is_load = 1'b0;
    logic        ex_is_store = 1'b0;
    logic        ex_reg_write = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wr_n;
    logic [4:0]  wr_addr;
    logic [31:0] data_in;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_funct3(ex_funct3),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wr_n(wr_n), .wr_addr(wr_addr), .data_in(data_in), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    typedef struct {
        bit          ld, st, rw;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] res, sd, rdat;
        int          dly;
        bit          e_err, e_wr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit ld, bit st, bit rw, logic [4:0] rd, logic [2:0] f3,
                                logic [31:0] res, logic [31:0] sd, logic [31:0] rdat, int dly,
                                bit e_err, bit e_wr, logic [31:0] e_data,
                                logic [3:0] e_be, logic [31:0] e_wdata);
        vec_t v;
        v.ld = ld; v.st = st; v.rw = rw; v.rd = rd; v.f3 = f3;
        v.res = res; v.sd = sd; v.rdat = rdat; v.dly = dly;
        v.e_err = e_err; v.e_wr = e_wr; v.e_data = e_data;
        v.e_be = e_be; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference model from the access rules: size in bytes, offset in word,
    // byte replication by multiplication, shift-and-mask extraction.
    function automatic void model(input bit ld, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] sd,
                                  input logic [31:0] rdat, output bit bad,
                                  output logic [3:0] be, output logic [31:0] wd,
                                  output logic [31:0] lv);
        int off, sz;
        bit ok;
        logic [31:0] t, mask;
        off = int'(a % 32'd4);
        if (ld) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        sz  = 1 << f3[1:0];
        bad = !ok || ((off % sz) != 0);
        be  = 4'(((1 << sz) - 1) << off);
        if (sz == 1)      wd = {24'h0, sd[7:0]} * 32'h0101_0101;
        else if (sz == 2) wd = {16'h0, sd[15:0]} * 32'h0001_0001;
        else              wd = sd;
        t    = rdat >> (8 * off);
        mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        lv   = t & mask;
        if (!f3[2] && sz < 4) begin
            if (lv[8*sz-1]) lv = lv | ~mask;
        end
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int guard = 0;
        while (!ex_ready && guard < 20) begin
            step();
            guard++;
        end
        chk({tag, " ready_wait"}, 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_rd = v.rd; ex_result = v.res; ex_store_data = v.sd;
        ex_funct3 = v.f3; ex_is_load = v.ld; ex_is_store = v.st; ex_reg_write = v.rw;
        step();
        ex_valid = 1'b0;
        if (!(v.ld || v.st)) begin
            chk({tag, " alu wr_n"}, 32'(wr_n), 32'(!v.e_wr));
            if (v.e_wr) begin
                chk({tag, " alu wr_addr"}, 32'(wr_addr), 32'(v.rd));
                chk({tag, " alu data_in"}, data_in, v.e_data);
            end
            chk({tag, " alu err"}, 32'(err), 32'd0);
            chk({tag, " alu req"}, 32'(dmem_req), 32'd0);
        end else if (v.e_err) begin
            chk({tag, " bad err"}, 32'(err), 32'd1);
            chk({tag, " bad req"}, 32'(dmem_req), 32'd0);
            chk({tag, " bad wr_n"}, 32'(wr_n), 32'd1);
            step();
            chk({tag, " bad err pulse"}, 32'(err), 32'd0);
            chk({tag, " bad req2"}, 32'(dmem_req), 32'd0);
        end else begin
            for (int k = 0; k < v.dly; k++) begin
                chk({tag, " req"}, 32'(dmem_req), 32'd1);
                chk({tag, " addr"}, dmem_addr, v.res & 32'hFFFF_FFFC);
                chk({tag, " we"}, 32'(dmem_we), 32'(v.st && !v.ld));
                if (v.st && !v.ld) begin
                    chk({tag, " be"}, 32'(dmem_be), 32'(v.e_be));
                    chk({tag, " wdata"}, dmem_wdata, v.e_wdata);
                end
                chk({tag, " wr_n in mem"}, 32'(wr_n), 32'd1);
                if (k == v.dly - 1) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = v.rdat;
                end
                step();
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
            end
            chk({tag, " req drop"}, 32'(dmem_req), 32'd0);
            chk({tag, " err"}, 32'(err), 32'd0);
            if (v.ld) begin
                chk({tag, " ld wr_n"}, 32'(wr_n), 32'(!v.e_wr));
                if (v.e_wr) begin
                    chk({tag, " ld wr_addr"}, 32'(wr_addr), 32'(v.rd));
                    chk({tag, " ld data_in"}, data_in, v.e_data);
                end
                step();
                chk({tag, " ld wr_n one cycle"}, 32'(wr_n), 32'd1);
                chk({tag, " ld ready back"}, 32'(ex_ready), 32'd1);
            end else begin
                chk({tag, " st wr_n"}, 32'(wr_n), 32'd1);
                chk({tag, " st ready back"}, 32'(ex_ready), 32'd1);
            end
        end
    endtask

    initial begin
        vec_t tbl[13];
        vec_t v;
        bit bad;
        logic [3:0] be;
        logic [31:0] wd, lv;
        int cls, rcyc;

        tbl[0]  = mk(1,0,1,5'd9,3'd0,32'h1003,32'h0,32'h80AB_CDEF,4,0,1,32'hFFFF_FF80,4'h0,32'h0);
        tbl[1]  = mk(0,1,0,5'd2,3'd1,32'h2002,32'h0000_BEEF,32'h0,2,0,0,32'h0,4'b1100,32'hBEEF_BEEF);
        tbl[2]  = mk(1,0,1,5'd3,3'd2,32'h0006,32'h0,32'h0,1,1,0,32'h0,4'h0,32'h0);
        tbl[3]  = mk(1,0,1,5'd3,3'd1,32'h0001,32'h0,32'h0,1,1,0,32'h0,4'h0,32'h0);
        tbl[4]  = mk(1,0,1,5'd0,3'd4,32'h0010,32'h0,32'h0000_00FF,1,0,0,32'h0,4'h0,32'h0);
        tbl[5]  = mk(1,0,1,5'd3,3'd1,32'h0002,32'h0,32'h8001_1234,1,0,1,32'hFFFF_8001,4'h0,32'h0);
        tbl[6]  = mk(0,1,0,5'd0,3'd0,32'h0101,32'h1234_5678,32'h0,3,0,0,32'h0,4'b0010,32'h7878_7878);
        tbl[7]  = mk(0,1,0,5'd0,3'd2,32'h0200,32'hDEAD_BEEF,32'h0,1,0,0,32'h0,4'hF,32'hDEAD_BEEF);
        tbl[8]  = mk(0,0,1,5'd4,3'd0,32'h0055,32'h0,32'h0,0,0,1,32'h0055,4'h0,32'h0);
        tbl[9]  = mk(1,0,1,5'd3,3'd3,32'h0040,32'h0,32'h0,1,1,0,32'h0,4'h0,32'h0);
        tbl[10] = mk(1,0,1,5'd7,3'd5,32'h0006,32'h0,32'h8001_0000,2,0,1,32'h0000_8001,4'h0,32'h0);
        tbl[11] = mk(0,0,1,5'd0,3'd0,32'h0099,32'h0,32'h0,0,0,0,32'h0,4'h0,32'h0);
        tbl[12] = mk(0,1,0,5'd0,3'd4,32'h0000,32'h5,32'h0,1,1,0,32'h0,4'h0,32'h0);

        // Reset state
        step(); step();
        chk("rst ex_ready", 32'(ex_ready), 32'd0);
        chk("rst wr_n", 32'(wr_n), 32'd1);
        chk("rst wr_addr", 32'(wr_addr), 32'd0);
        chk("rst data_in", data_in, 32'd0);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst we", 32'(dmem_we), 32'd0);
        chk("rst addr", dmem_addr, 32'd0);
        chk("rst wdata", dmem_wdata, 32'd0);
        chk("rst be", 32'(dmem_be), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst ex_ready", 32'(ex_ready), 32'd1);

        // Three back-to-back ALU ops
        ex_reg_write = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_rd = 5'(5 + i);
            ex_result = 32'(32'h11 * (i + 1));
            chk("b2b ex_ready", 32'(ex_ready), 32'd1);
            step();
            chk("b2b wr_n", 32'(wr_n), 32'd0);
            chk("b2b wr_addr", 32'(wr_addr), 32'(5 + i));
            chk("b2b data_in", data_in, 32'(32'h11 * (i + 1)));
        end
        ex_valid = 1'b0;
        step();
        chk("b2b wr_n idle", 32'(wr_n), 32'd1);

        // Directed table
        foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Timeout: no ack, req held TO cycles, then err; late ack ignored
        v = mk(1,0,1,5'd8,3'd2,32'h0300,32'h0,32'h0,1,0,0,32'h0,4'h0,32'h0);
        ex_valid = 1'b1; ex_rd = v.rd; ex_result = v.res; ex_funct3 = v.f3;
        ex_is_load = 1'b1; ex_is_store = 1'b0; ex_reg_write = 1'b1;
        step();
        ex_valid = 1'b0;
        rcyc = 0;
        for (int k = 0; k < TO + 2; k++) begin
            if (dmem_req) rcyc++;
            else break;
            step();
        end
        chk("timeout req cycles", 32'(rcyc), 32'(TO));
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout wr_n", 32'(wr_n), 32'd1);
        chk("timeout ready", 32'(ex_ready), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        step();
        dmem_ack = 1'b0;
        chk("late ack wr_n", 32'(wr_n), 32'd1);
        chk("late ack err", 32'(err), 32'd0);
        chk("late ack req", 32'(dmem_req), 32'd0);
        step();
        chk("late ack wr_n2", 32'(wr_n), 32'd1);

        // Reset while in MEM
        ex_valid = 1'b1; ex_result = 32'h0400;
        step();
        ex_valid = 1'b0;
        chk("rstmem req up", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmem ready low", 32'(ex_ready), 32'd0);
        step();
        chk("rstmem req", 32'(dmem_req), 32'd0);
        chk("rstmem err", 32'(err), 32'd0);
        rst = 1'b0;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("rstmem late ack wr_n", 32'(wr_n), 32'd1);
        chk("rstmem late ack req", 32'(dmem_req), 32'd0);
        step();
        chk("rstmem wr_n2", 32'(wr_n), 32'd1);

        // Randomized transactions against the reference model
        for (int n = 0; n < 150; n++) begin
            cls = $urandom_range(0, 2);
            v.rd = 5'($urandom_range(0, 31));
            v.res = $urandom;
            v.sd = $urandom;
            v.rdat = $urandom;
            v.dly = $urandom_range(1, TO);
            v.f3 = 3'($urandom_range(0, 7));
            v.e_be = '0; v.e_wdata = '0;
            if (cls == 0) begin
                v.ld = 0; v.st = 0; v.rw = ($urandom_range(0, 3) != 0);
                v.e_err = 0; v.e_wr = v.rw && (v.rd != 0); v.e_data = v.res;
            end else begin
                v.ld = (cls == 1); v.st = (cls == 2); v.rw = v.ld;
                model(v.ld, v.f3, v.res, v.sd, v.rdat, bad, be, wd, lv);
                v.e_err = bad; v.e_be = be; v.e_wdata = wd; v.e_data = lv;
                v.e_wr = v.ld && !bad && (v.rd != 0);
            end
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
